// File: rtl/ysyx_25030093_lsu_ext_if.sv
// LSU memory request port: single-outstanding request/response bus between
// the LSU (master) and the memory/MMIO fabric (slave).
//   lsu_reqValid  master->slave  request valid, held until response or timeout
//   lsu_addr      master->slave  byte address (word-aligned outside MMIO)
//   lsu_size      master->slave  00 byte, 01 half, 10 word
//   lsu_wen       master->slave  1 = write
//   lsu_wdata     master->slave  write data already shifted to its byte lane
//   lsu_wmask     master->slave  byte strobes (0000 for reads)
//   lsu_respValid slave->master  response / write acknowledge
//   lsu_rdata     slave->master  read data
interface ysyx_25030093_lsu_ext_if;
    logic        lsu_reqValid;
    logic [31:0] lsu_addr;
    logic [1:0]  lsu_size;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_respValid;
    logic [31:0] lsu_rdata;

    modport master (
        output lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask,
        input  lsu_respValid, lsu_rdata
    );

    modport slave (
        input  lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask,
        output lsu_respValid, lsu_rdata
    );
endinterface

// File: rtl/ysyx_25030093_lsu_ext.sv
// Load/store unit between EXU and WBU. Accepts one RV32I load/store at a
// time, checks it, issues a single bus request, and holds the completion
// (load data or error) until WBU takes it.
// Ports:
//   clock, reset           clock; asynchronous active-high reset
//   in_valid / out_ready   request handshake from EXU
//   addr, wdata, funct3,   effective address, store data, access type,
//   is_store               load/store select
//   out_valid / in_ready   completion handshake to WBU
//   LSU_data               load result (0 for stores and errors)
//   lsu_err, err_cause     error flag; 01 misaligned, 10 timeout, 11 illegal
//   bus                    memory request port (master side)
//
// state | meaning
// IDLE  | ready for a new request
// REQ   | bus request outstanding, timeout counter running
// DONE  | completion presented to WBU, waiting for in_ready
module ysyx_25030093_lsu_ext #(
    parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
    parameter logic [31:0] MMIO_LIMIT = 32'h1000_0fff,
    parameter int          TIMEOUT    = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        out_ready,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    input  logic        is_store,
    output logic        out_valid,
    input  logic        in_ready,
    output logic [31:0] LSU_data,
    output logic        lsu_err,
    output logic [1:0]  err_cause,
    ysyx_25030093_lsu_ext_if.master bus
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    // Down-counter: loaded with TIMEOUT-1 on accept, so reaching zero in REQ
    // marks the TIMEOUT-th request cycle.
    localparam logic [15:0] TO_LOAD = 16'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [2:0]  f3_q;
    logic        st_q;
    logic [1:0]  alo_q;
    logic        mmio_q;
    logic [15:0] cnt;

    logic        mmio;
    logic        illegal;
    logic        misal;
    logic [3:0]  base_mask;
    logic [31:0] raw;
    logic [31:0] load_res;

    always_comb begin
        mmio    = (addr >= MMIO_BASE) && (addr <= MMIO_LIMIT);
        illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111)
                  || (is_store && funct3[2]);
        misal   = ((funct3[1:0] == 2'b01) && addr[0])
                  || ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        case (funct3[1:0])
            2'b00:   base_mask = 4'b0001;
            2'b01:   base_mask = 4'b0011;
            default: base_mask = 4'b1111;
        endcase
    end

    // MMIO devices return data already at bit 0; memory returns the full word.
    always_comb begin
        raw = mmio_q ? bus.lsu_rdata : (bus.lsu_rdata >> {alo_q, 3'b000});
        case (f3_q)
            3'b000:  load_res = {{24{raw[7]}}, raw[7:0]};
            3'b001:  load_res = {{16{raw[15]}}, raw[15:0]};
            3'b100:  load_res = {24'd0, raw[7:0]};
            3'b101:  load_res = {16'd0, raw[15:0]};
            default: load_res = raw;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        out_ready        = 1'b0;
        out_valid        = 1'b0;
        bus.lsu_reqValid = 1'b0;
        case (state)
            IDLE: begin
                out_ready = 1'b1;
                if (in_valid) state_nxt = (illegal || misal) ? DONE : REQ;
            end
            REQ: begin
                bus.lsu_reqValid = 1'b1;
                if (bus.lsu_respValid || (cnt == 16'd0)) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (in_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            f3_q          <= 3'd0;
            st_q          <= 1'b0;
            alo_q         <= 2'd0;
            mmio_q        <= 1'b0;
            cnt           <= 16'd0;
            bus.lsu_addr  <= 32'd0;
            bus.lsu_size  <= 2'd0;
            bus.lsu_wen   <= 1'b0;
            bus.lsu_wdata <= 32'd0;
            bus.lsu_wmask <= 4'd0;
            LSU_data      <= 32'd0;
            lsu_err       <= 1'b0;
            err_cause     <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        f3_q   <= funct3;
                        st_q   <= is_store;
                        alo_q  <= addr[1:0];
                        mmio_q <= mmio;
                        cnt    <= TO_LOAD;
                        if (illegal) begin
                            LSU_data  <= 32'd0;
                            lsu_err   <= 1'b1;
                            err_cause <= 2'b11;
                        end else if (misal) begin
                            LSU_data  <= 32'd0;
                            lsu_err   <= 1'b1;
                            err_cause <= 2'b01;
                        end else begin
                            bus.lsu_addr  <= mmio ? addr : {addr[31:2], 2'b00};
                            bus.lsu_size  <= funct3[1:0];
                            bus.lsu_wen   <= is_store;
                            bus.lsu_wdata <= wdata << {addr[1:0], 3'b000};
                            bus.lsu_wmask <= is_store ? (base_mask << addr[1:0]) : 4'b0000;
                        end
                    end
                end
                REQ: begin
                    // A response on the terminal-count cycle wins over timeout.
                    if (bus.lsu_respValid) begin
                        LSU_data  <= st_q ? 32'd0 : load_res;
                        lsu_err   <= 1'b0;
                        err_cause <= 2'b00;
                    end else if (cnt == 16'd0) begin
                        LSU_data  <= 32'd0;
                        lsu_err   <= 1'b1;
                        err_cause <= 2'b10;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25030093_lsu_ext.sv
module tb_ysyx_25030093_lsu_ext;

    localparam logic [31:0] MMIO_BASE  = 32'h1000_0000;
    localparam logic [31:0] MMIO_LIMIT = 32'h1000_0fff;
    localparam int          TIMEOUT    = 4;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic        is_store;
    logic        out_valid;
    logic        in_ready;
    logic [31:0] LSU_data;
    logic        lsu_err;
    logic [1:0]  err_cause;

    ysyx_25030093_lsu_ext_if bus ();

    ysyx_25030093_lsu_ext #(
        .MMIO_BASE (MMIO_BASE),
        .MMIO_LIMIT(MMIO_LIMIT),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .out_ready(out_ready),
        .addr     (addr),
        .wdata    (wdata),
        .funct3   (funct3),
        .is_store (is_store),
        .out_valid(out_valid),
        .in_ready (in_ready),
        .LSU_data (LSU_data),
        .lsu_err  (lsu_err),
        .err_cause(err_cause),
        .bus      (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: expected load value from the access rules.
    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] a,
                                               input logic [2:0] f3, input logic in_mmio);
        int          nb;
        logic [31:0] r;
        logic [31:0] m;
        logic [31:0] v;
        nb = 1 << f3[1:0];
        r  = in_mmio ? rd : rd >> (8 * a[1:0]);
        m  = (nb == 4) ? 32'hffff_ffff : ((32'd1 << (8 * nb)) - 32'd1);
        v  = r & m;
        if (!f3[2] && nb < 4 && r[8 * nb - 1]) v = v | ~m;
        return v;
    endfunction

    // d: response offered in REQ cycle d+1; d >= TIMEOUT means never.
    // h: cycles WBU holds in_ready low in DONE.
    task automatic do_op(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                         input logic st, input int d, input logic [31:0] rd, input int h);
        logic        is_mmio, ill, mis, resp;
        logic [1:0]  exp_cause;
        logic [31:0] exp_data;
        int          nb, rv_cycles;
        is_mmio = (a >= MMIO_BASE) && (a <= MMIO_LIMIT);
        ill     = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (st && f3[2]);
        nb      = 1 << f3[1:0];
        mis     = !ill && (a % nb != 0);
        check("out_ready_idle", {31'd0, out_ready}, 32'd1);
        addr = a; wdata = wd; funct3 = f3; is_store = st; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        if (ill || mis) begin
            exp_cause = ill ? 2'b11 : 2'b01;
            exp_data  = 32'd0;
            check("err_reqvalid", {31'd0, bus.lsu_reqValid}, 32'd0);
            check("err_out_valid", {31'd0, out_valid}, 32'd1);
        end else begin
            check("lsu_addr", bus.lsu_addr, is_mmio ? a : (a & 32'hffff_fffc));
            check("lsu_size", {30'd0, bus.lsu_size}, {30'd0, f3[1:0]});
            check("lsu_wen", {31'd0, bus.lsu_wen}, {31'd0, st});
            check("lsu_wdata", bus.lsu_wdata, wd << (8 * a[1:0]));
            check("lsu_wmask", {28'd0, bus.lsu_wmask},
                  st ? ((((32'd1 << nb) - 32'd1) << a[1:0]) & 32'hf) : 32'd0);
            rv_cycles = 0;
            resp      = 1'b0;
            for (int k = 1; k <= TIMEOUT; k++) begin
                if (bus.lsu_reqValid) rv_cycles++;
                check("no_early_done", {31'd0, out_valid}, 32'd0);
                if (k == d + 1) begin
                    bus.lsu_respValid = 1'b1;
                    bus.lsu_rdata     = rd;
                    resp              = 1'b1;
                end
                @(posedge clock); #1;
                bus.lsu_respValid = 1'b0;
                if (resp) break;
            end
            check("req_cycles", rv_cycles, resp ? d + 1 : TIMEOUT);
            check("req_dropped", {31'd0, bus.lsu_reqValid}, 32'd0);
            check("out_valid", {31'd0, out_valid}, 32'd1);
            exp_cause = resp ? 2'b00 : 2'b10;
            exp_data  = (resp && !st) ? model_load(rd, a, f3, is_mmio) : 32'd0;
        end
        in_ready = 1'b0;
        for (int i = 0; i <= h; i++) begin
            check("done_valid", {31'd0, out_valid}, 32'd1);
            check("LSU_data", LSU_data, exp_data);
            check("lsu_err", {31'd0, lsu_err}, {31'd0, exp_cause != 2'b00});
            check("err_cause", {30'd0, err_cause}, {30'd0, exp_cause});
            if (i < h) begin
                bus.lsu_respValid = 1'($urandom_range(0, 1));
                bus.lsu_rdata     = $urandom;
                @(posedge clock); #1;
            end
        end
        bus.lsu_respValid = 1'b0;
        in_ready = 1'b1;
        @(posedge clock); #1;
        in_ready = 1'b0;
        check("back_idle_ready", {31'd0, out_ready}, 32'd1);
        check("back_idle_valid", {31'd0, out_valid}, 32'd0);
        check("held_data", LSU_data, exp_data);
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  f3;
        logic        st;
        int          sel, dly;

        reset = 1'b1; in_valid = 1'b0; in_ready = 1'b0;
        addr = '0; wdata = '0; funct3 = '0; is_store = 1'b0;
        bus.lsu_respValid = 1'b0; bus.lsu_rdata = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_reqvalid", {31'd0, bus.lsu_reqValid}, 32'd0);
        check("rst_LSU_data", LSU_data, 32'd0);
        check("rst_err", {29'd0, lsu_err, err_cause}, 32'd0);
        check("rst_bus", bus.lsu_addr | bus.lsu_wdata | {28'd0, bus.lsu_wmask}, 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        check("rst_out_ready", {31'd0, out_ready}, 32'd1);

        // Directed cases from the access rules.
        do_op(32'h8000_0003, 32'h0,         3'b000, 1'b0, 0, 32'h80FF_1234, 1);
        do_op(32'h8000_0002, 32'h0000_ABCD, 3'b001, 1'b1, 1, 32'h0,         0);
        do_op(32'h1000_03F9, 32'h0000_0041, 3'b000, 1'b1, 0, 32'h0,         0);
        do_op(32'h1000_03F9, 32'h0,         3'b100, 1'b0, 2, 32'h0000_005A, 0);
        do_op(32'h8000_0006, 32'h0,         3'b010, 1'b0, 0, 32'h0,         0);
        do_op(32'h8000_0000, 32'h0,         3'b011, 1'b0, 0, 32'h0,         0);
        do_op(32'h8000_0004, 32'h1,         3'b100, 1'b1, 0, 32'h0,         0);
        do_op(32'h8000_0010, 32'h0,         3'b010, 1'b0, TIMEOUT,     32'h0,         1);
        do_op(32'h8000_0010, 32'h0,         3'b010, 1'b0, TIMEOUT - 1, 32'hDEAD_BEEF, 0);
        do_op(32'h8000_0022, 32'h0,         3'b001, 1'b0, 0, 32'h8001_7FFF, 5);
        do_op(32'h0FFF_FFFF, 32'h0,         3'b000, 1'b0, 0, 32'h7F00_0000, 0);
        do_op(32'h1000_1001, 32'h0,         3'b100, 1'b0, 0, 32'h00AB_0000, 0);

        // Reset in the middle of a request.
        addr = 32'h8000_0100; funct3 = 3'b010; is_store = 1'b1; wdata = 32'h1234_5678;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        check("mid_req_active", {31'd0, bus.lsu_reqValid}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_reqvalid", {31'd0, bus.lsu_reqValid}, 32'd0);
        check("mid_rst_wmask", {28'd0, bus.lsu_wmask}, 32'd0);
        check("mid_rst_addr", bus.lsu_addr, 32'd0);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        #1;
        reset = 1'b0;
        bus.lsu_respValid = 1'b1; bus.lsu_rdata = 32'hFFFF_FFFF;
        @(posedge clock); #1;
        bus.lsu_respValid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("late_resp_ignored", {31'd0, out_valid}, 32'd0);
        check("late_resp_ready", {31'd0, out_ready}, 32'd1);
        check("late_resp_data", LSU_data, 32'd0);

        // Randomized operations.
        for (int n = 0; n < 200; n++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       a = 32'h8000_0000 | ($urandom & 32'h0000_0fff);
                1:       a = MMIO_BASE + $urandom_range(0, 32'hfff);
                2:       a = MMIO_BASE - 32'd4 + $urandom_range(0, 3);
                default: a = MMIO_LIMIT - 32'd1 + $urandom_range(0, 3);
            endcase
            f3  = 3'($urandom_range(0, 7));
            st  = 1'($urandom_range(0, 1));
            dly = $urandom_range(0, TIMEOUT + 1);
            do_op(a, $urandom, f3, st, dly, $urandom, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
